// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite transfer codes, slave FSM states and the byte-lane helper.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RD_STALL,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // NONSEQ and SEQ are the only transfer types that open a data phase.
    function automatic logic trans_active(input logic [1:0] htrans);
        logic active;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
        return active;
    endfunction

    // Byte lanes touched by a transfer of the given size at the given byte offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] mask;
        case (size)
            HSIZE_BYTE: mask = 4'b0001 << addr;
            HSIZE_HALF: mask = 4'b0011 << {addr[1], 1'b0};
            HSIZE_WORD: mask = 4'b1111;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb3lite_addr_decode.sv
// Combinational address-phase decode: legality, BRAM word index and byte lanes.
module ahb3lite_addr_decode
    import ahb3lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_BYTES  = 16384,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    BRAM_AW    = $clog2(MEM_BYTES) - 2
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    output logic                  legal,
    output logic [BRAM_AW-1:0]    word_addr,
    output logic [3:0]            lanes
);

    localparam logic [ADDR_WIDTH-1:0] MEM_SIZE = ADDR_WIDTH'(MEM_BYTES);

    logic [ADDR_WIDTH-1:0] offset;
    logic                  aligned;

    // Offsets below the base wrap to huge values, so one unsigned compare covers both ends.
    always_comb begin
        offset = addr - BASE_ADDR;
        case (size)
            HSIZE_HALF: aligned = ~offset[0];
            HSIZE_WORD: aligned = (offset[1:0] == 2'b00);
            default:    aligned = 1'b1;
        endcase
        legal     = (size <= HSIZE_WORD) && aligned && (offset < MEM_SIZE);
        word_addr = offset[BRAM_AW+1:2];
        lanes     = lane_mask(size, offset[1:0]);
    end

endmodule

// File: rtl/ahb3lite_bram_slave.sv
// AHB-Lite slave mapping the instruction port onto a single-port, 1-cycle-latency BRAM.
module ahb3lite_bram_slave
    import ahb3lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_BYTES  = 16384,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    BRAM_AW    = $clog2(MEM_BYTES) - 2
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HMASTLOCK,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic [BRAM_AW-1:0]    bram_addr,
    output logic [31:0]           bram_wdata,
    input  logic [31:0]           bram_rdata
);

    state_t               state;
    state_t               state_nxt;
    logic [BRAM_AW-1:0]   wr_addr;
    logic [3:0]           wr_lanes;
    logic [BRAM_AW-1:0]   rd_addr;
    logic [31:0]          rdata_hold;

    logic                 dec_legal;
    logic [BRAM_AW-1:0]   dec_word;
    logic [3:0]           dec_lanes;

    logic                 addr_phase;
    logic                 accept;
    logic                 acc_rd;
    logic                 acc_wr;
    logic                 acc_err;
    logic                 unused_inputs;

    // Burst type, protection and lock carry no meaning for a plain memory.
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK};

    ahb3lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_BYTES  (MEM_BYTES),
        .BASE_ADDR  (BASE_ADDR),
        .BRAM_AW    (BRAM_AW)
    ) u_decode (
        .addr      (HADDR),
        .size      (HSIZE),
        .legal     (dec_legal),
        .word_addr (dec_word),
        .lanes     (dec_lanes)
    );

    // Response flags depend only on state, keeping HREADYOUT free of any input path.
    assign HREADYOUT = (state != ST_ERR1) && (state != ST_RD_STALL);
    assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (state == ST_RD) ? bram_rdata : rdata_hold;

    // ERR1 and RD_STALL hold the bus, so no address phase is sampled in them.
    assign addr_phase = (state != ST_ERR1) && (state != ST_RD_STALL);
    assign accept     = HSEL & HREADY & trans_active(HTRANS) & addr_phase;
    assign acc_rd     = accept & dec_legal & ~HWRITE;
    assign acc_wr     = accept & dec_legal & HWRITE;
    assign acc_err    = accept & ~dec_legal;

    // Next state and BRAM port drive; a write data phase owns the port over a new read.
    always_comb begin
        state_nxt  = ST_IDLE;
        bram_en    = 1'b0;
        bram_we    = 4'b0000;
        bram_addr  = dec_word;
        bram_wdata = HWDATA;

        case (state)
            ST_WR: begin
                bram_en   = 1'b1;
                bram_we   = wr_lanes;
                bram_addr = wr_addr;
            end
            ST_RD_STALL: begin
                bram_en   = 1'b1;
                bram_addr = rd_addr;
            end
            default: ;
        endcase

        if (state == ST_ERR1) begin
            state_nxt = ST_ERR2;
        end else if (state == ST_RD_STALL) begin
            state_nxt = ST_RD;
        end else if (acc_rd) begin
            if (state == ST_WR) begin
                state_nxt = ST_RD_STALL;
            end else begin
                state_nxt = ST_RD;
                bram_en   = 1'b1;
                bram_we   = 4'b0000;
                bram_addr = dec_word;
            end
        end else if (acc_wr) begin
            state_nxt = ST_WR;
        end else if (acc_err) begin
            state_nxt = ST_ERR1;
        end

        // A reset cycle abandons the transfer and must never touch memory.
        if (HRESET) begin
            bram_en = 1'b0;
            bram_we = 4'b0000;
        end
    end

    // State register plus the address-phase fields that outlive their bus cycle.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            wr_addr    <= '0;
            wr_lanes   <= 4'b0000;
            rd_addr    <= '0;
            rdata_hold <= 32'h0;
        end else begin
            state <= state_nxt;
            if (acc_wr) begin
                wr_addr  <= dec_word;
                wr_lanes <= dec_lanes;
            end
            if (acc_rd && (state == ST_WR)) begin
                rd_addr <= dec_word;
            end
            if (state == ST_RD) begin
                rdata_hold <= bram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ahb3lite_bram_slave.sv
// Scoreboard bench for ahb3lite_bram_slave: directed cases plus random AHB traffic.
module tb_ahb3lite_bram_slave;

    localparam int          MEM_BYTES = 16384;
    localparam int          BRAM_AW   = 12;
    localparam logic [31:0] BASE_ADDR = 32'h0;

    logic               HCLK = 1'b0;
    logic               HRESET;
    logic               HSEL;
    logic [31:0]        HADDR;
    logic [1:0]         HTRANS;
    logic               HWRITE;
    logic [2:0]         HSIZE;
    logic [2:0]         HBURST;
    logic [3:0]         HPROT;
    logic               HMASTLOCK;
    logic [31:0]        HWDATA;
    logic               HREADY;
    logic [31:0]        HRDATA;
    logic               HREADYOUT;
    logic               HRESP;
    logic               bram_en;
    logic [3:0]         bram_we;
    logic [BRAM_AW-1:0] bram_addr;
    logic [31:0]        bram_wdata;
    logic [31:0]        bram_rdata;

    logic               load_en;
    logic [11:0]        load_addr;
    logic [31:0]        load_data;
    logic [31:0]        bmem [0:4095];

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] ref_mem [0:4095];
    int          checks = 0;
    int          failures = 0;

    bit          prev_wr = 1'b0;
    logic [3:0]  prev_lanes = 4'b0;
    logic [11:0] prev_word = 12'h0;
    logic [31:0] pending_wdata = 32'h0;

    always #5 HCLK = ~HCLK;

    // Single slave on the bus: the bus-level ready is this slave's ready.
    assign HREADY = HREADYOUT;

    ahb3lite_bram_slave #(
        .ADDR_WIDTH (32),
        .MEM_BYTES  (MEM_BYTES),
        .BASE_ADDR  (BASE_ADDR)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HPROT      (HPROT),
        .HMASTLOCK  (HMASTLOCK),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HRDATA     (HRDATA),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata)
    );

    // Synchronous single-port BRAM with a preload port used only during reset.
    always @(posedge HCLK) begin
        if (load_en) begin
            bmem[load_addr] <= load_data;
        end else if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) bmem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
            bram_rdata <= bmem[bram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] addr, input logic [2:0] size);
        if (size > 3'd2) return 1'b0;
        if ((addr % (32'd1 << size)) != 32'd0) return 1'b0;
        return (addr - BASE_ADDR) < 32'(MEM_BYTES);
    endfunction

    function automatic logic [3:0] exp_lanes(input logic [31:0] addr, input logic [2:0] size);
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 0; i < (1 << size); i++) m[2'(int'(addr[1:0]) + i)] = 1'b1;
        return m;
    endfunction

    // Byte-addressed memory model: byte at address A travels on lane A mod 4.
    task automatic ref_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        logic [31:0] a;
        for (int i = 0; i < (1 << size); i++) begin
            a = addr + 32'(i);
            ref_mem[a[13:2]][8*a[1:0] +: 8] = data[8*a[1:0] +: 8];
        end
    endtask

    // Present one address phase, hold it until accepted, and record the expected response.
    task automatic do_beat(input logic sel, input logic [1:0] trans, input logic write,
                           input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int   guard;
        bit   acc;
        bit   legal;
        bit   stall;
        exp_t e;
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = write;
        HSIZE  = size;
        HADDR  = addr;
        HWDATA = pending_wdata;
        acc    = sel && trans[1];
        legal  = is_legal(addr, size);
        @(negedge HCLK);
        if (prev_wr) begin
            check("wr_lanes", 32'(bram_we), 32'(prev_lanes));
            check("wr_addr", 32'(bram_addr), 32'(prev_word));
            check("wr_en", 32'(bram_en), 32'd1);
        end
        guard = 0;
        while (!HREADYOUT && guard < 8) begin
            @(negedge HCLK);
            guard++;
        end
        if (!HREADYOUT) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: HREADYOUT stuck at %b, need 1", HREADYOUT);
        end
        if (acc && !legal && !prev_wr) check("err_addr_en", 32'(bram_en), 32'd0);
        if (acc && legal && !write && !prev_wr)
            check("rd_addr_phase", 32'({bram_en, bram_we, bram_addr}), 32'({1'b1, 4'b0000, addr[13:2]}));
        @(posedge HCLK);
        #1;
        stall   = prev_wr;
        prev_wr = 1'b0;
        if (acc) begin
            e.err   = !legal;
            e.rd    = !write;
            e.waits = (!legal || (!write && stall)) ? 1 : 0;
            if (legal && write) begin
                ref_write(addr, size, wdata);
                prev_wr    = 1'b1;
                prev_lanes = exp_lanes(addr, size);
                prev_word  = addr[13:2];
            end
            e.data = ref_mem[addr[13:2]];
            expq.push_back(e);
        end
        pending_wdata = (acc && legal && write) ? wdata : $urandom;
    endtask

    // Monitor: follows data phases on the bus and retires one expectation per completion.
    initial begin : monitor
        bit   active;
        int   waits;
        exp_t e;
        active = 1'b0;
        waits  = 0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                active = 1'b0;
                waits  = 0;
            end else begin
                if (active) begin
                    if (expq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_dphase: queue empty, HRESP=%b", HRESP);
                        active = 1'b0;
                    end else if (!HREADYOUT) begin
                        waits++;
                        if (expq[0].err) begin
                            check("err1_resp", 32'(HRESP), 32'd1);
                            check("err1_bram_en", 32'(bram_en), 32'd0);
                        end
                    end else begin
                        e = expq.pop_front();
                        check("resp", 32'(HRESP), 32'(e.err));
                        check("waits", 32'(waits), 32'(e.waits));
                        if (e.rd && !e.err) check("rdata", HRDATA, e.data);
                        active = 1'b0;
                        waits  = 0;
                    end
                end
                if (HREADYOUT) active = HSEL && HTRANS[1];
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int          kind;
        int          sub;
        logic [31:0] a;
        logic [2:0]  s;
        logic        w;
        HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'd0; HWRITE = 1'b0;
        HSIZE = 3'd0; HBURST = 3'd0; HPROT = 4'd0; HMASTLOCK = 1'b0; HWDATA = 32'h0;
        load_en = 1'b0; load_addr = 12'h0; load_data = 32'h0;

        for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
        for (int i = 0; i < 128; i++) ref_mem[i] = $urandom;
        ref_mem[0] = 32'd1; ref_mem[1] = 32'd2; ref_mem[2] = 32'd3; ref_mem[3] = 32'd4;
        ref_mem[5]  = 32'hDEADBEEF;
        ref_mem[8]  = 32'h0;
        ref_mem[12] = 32'hCAFEBABE;
        ref_mem[16] = 32'h11112222;

        @(posedge HCLK); #1;
        for (int i = 0; i < 128; i++) begin
            load_en = 1'b1; load_addr = 12'(i); load_data = ref_mem[i];
            @(posedge HCLK); #1;
        end
        load_en = 1'b0;
        HRESET  = 1'b0;
        @(negedge HCLK);
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_hresp", 32'(HRESP), 32'd0);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_bram_en", 32'(bram_en), 32'd0);
        check("rst_bram_we", 32'(bram_we), 32'd0);
        @(posedge HCLK); #1;

        // Single read of word 5.
        do_beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h14, 32'h0);
        // INCR4 read burst over words 0..3.
        HBURST = 3'd3;
        do_beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h0, 32'h0);
        do_beat(1'b1, 2'd3, 1'b0, 3'd2, 32'h4, 32'h0);
        do_beat(1'b1, 2'd3, 1'b0, 3'd2, 32'h8, 32'h0);
        do_beat(1'b1, 2'd3, 1'b0, 3'd2, 32'hC, 32'h0);
        HBURST = 3'd0;
        // Byte write then immediate read of the same word: one stall cycle.
        do_beat(1'b1, 2'd2, 1'b1, 3'd0, 32'h21, 32'h0000A500);
        do_beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h20, 32'h0);
        // Halfword write to the upper half of word 12, then read back.
        do_beat(1'b1, 2'd2, 1'b1, 3'd1, 32'h32, 32'h12340000);
        do_beat(1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 32'h0);
        do_beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h30, 32'h0);
        // Out-of-range and misaligned reads take the two-cycle ERROR path.
        do_beat(1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 32'h0);
        do_beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h4000, 32'h0);
        do_beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h2, 32'h0);
        do_beat(1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 32'h0);

        // Random traffic over the low 512 bytes with idle, busy and illegal beats mixed in.
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 99));
            s = 3'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 511));
            w = 1'($urandom_range(0, 1));
            if (kind < 15) begin
                do_beat(1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), w, s, a, $urandom);
            end else if (kind < 27) begin
                sub = int'($urandom_range(0, 3));
                if (sub == 0) begin
                    a = 32'h4000 + 32'($urandom_range(0, 255)) * 32'd4; s = 3'd2;
                end else if (sub == 1) begin
                    a = 32'hFFFF_FFFC; s = 3'd2;
                end else if (sub == 2) begin
                    a = (32'($urandom_range(0, 127)) << 2) + 32'($urandom_range(1, 3)); s = 3'd2;
                end else begin
                    a = a & ~32'h3; s = 3'($urandom_range(3, 7));
                end
                do_beat(1'b1, 2'($urandom_range(2, 3)), w, s, a, $urandom);
            end else begin
                a = a - (a % (32'd1 << s));
                do_beat(1'b1, 2'($urandom_range(2, 3)), w, s, a, $urandom);
            end
        end
        do_beat(1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 32'h0);
        do_beat(1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 32'h0);

        // Reset during a write data phase: no BRAM write, outputs back to reset values.
        HSEL = 1'b1; HTRANS = 2'd2; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h40;
        HWDATA = pending_wdata;
        @(negedge HCLK);
        @(posedge HCLK); #1;
        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'd0; HWRITE = 1'b0; HWDATA = 32'hFFFF_FFFF;
        @(negedge HCLK);
        check("rst_cycle_we", 32'(bram_we), 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        check("rst2_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst2_hresp", 32'(HRESP), 32'd0);
        check("rst2_hrdata", HRDATA, 32'h0);
        check("rst2_bram_en", 32'(bram_en), 32'd0);
        check("rst_mem_word16", bmem[16], ref_mem[16]);
        @(posedge HCLK); #1;
        prev_wr = 1'b0;
        do_beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h40, 32'h0);
        do_beat(1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 32'h0);
        do_beat(1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 32'h0);

        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb3lite_bram_slave.md
Name: ahb3lite_bram_slave

Overview:
- AHB-Lite slave that terminates the instruction master port produced by the core-to-AHB bridge.
- Maps the bus onto one single-port synchronous BRAM with 1-cycle read latency. Serves instruction fetches and debug/loader writes.
- Supports byte, halfword and word transfers; returns two-cycle ERROR for illegal accesses.

Parameters:
- ADDR_WIDTH, 32, AHB address width
- MEM_BYTES, 16384, memory size in bytes; power of two, min 8
- BASE_ADDR, 32'h0000_0000, first byte address decoded; aligned to MEM_BYTES
- BRAM_AW, $clog2(MEM_BYTES)-2, BRAM word-address width (derived)

Ports:
- HCLK  in  1  clock
- HRESET  in  1  synchronous active-high reset
- HSEL  in  1  slave select
- HADDR  in  ADDR_WIDTH  address-phase address
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  1=write
- HSIZE  in  3  0=byte, 1=half, 2=word
- HBURST  in  3  ignored; each beat is decoded independently
- HPROT  in  4  ignored
- HMASTLOCK  in  1  ignored
- HWDATA  in  32  data-phase write data
- HREADY  in  1  bus-level ready (phase advance)
- HRDATA  out  32  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR
- bram_en  out  1  BRAM port enable
- bram_we  out  4  byte write enables
- bram_addr  out  BRAM_AW  word address
- bram_wdata  out  32  write data
- bram_rdata  in  32  read data; valid 1 cycle after bram_en with bram_we=0

Behaviour:
- Clocking and reset:
  - HCLK is the single clock. HRESET is synchronous and active-high.
  - Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, bram_en=0, bram_we=0, state=IDLE, all latched address-phase fields cleared.
  - Reset mid-transfer abandons the transfer. No BRAM write occurs in the reset cycle.
- Transfer acceptance:
  - Accept when HSEL & HREADY & HTRANS[1].
  - IDLE or BUSY with HSEL & HREADY gets a zero-wait OKAY data phase.
- Legality check:
  - Legal when HSIZE<=2, HADDR aligned to HSIZE, and HADDR-BASE_ADDR < MEM_BYTES.
  - Otherwise the transfer is illegal and goes to ERR1. No BRAM access is made.
- Byte lanes:
  - size 0: bram_we = 1<<HADDR[1:0]
  - size 1: bram_we = 4'b0011 << {HADDR[1],1'b0}
  - size 2: bram_we = 4'b1111
- Reads:
  - HRDATA carries the full 32-bit word. The master selects the lanes.
- FSM states: IDLE, RD, WR, RD_STALL, ERR1, ERR2.
- IDLE / RD / WR, on an accepted legal read:
  - Drive bram_en=1, bram_we=0, bram_addr=HADDR word index combinationally in the address phase.
  - Next state RD. Exception: if the current state is WR, go to RD_STALL.
- RD:
  - HREADYOUT=1, HRDATA=bram_rdata. Zero wait states.
  - Back-to-back reads pipeline at 1 word/cycle.
- Accepted legal write:
  - Latch address and lanes. Next state WR.
- WR:
  - Drive bram_en=1, bram_we=latched lanes, bram_wdata=HWDATA, bram_addr=latched.
  - HREADYOUT=1.
- RD_STALL (read address phase collided with a write data phase; single port):
  - The read address is latched.
  - First cycle: HREADYOUT=0; BRAM read is issued from the latched address.
  - Next cycle: HREADYOUT=1 with the data. This returns the just-written value (read-after-write coherent).
  - A transfer accepted in that completing cycle is handled normally.
- ERR1:
  - HREADYOUT=0, HRESP=1. Always proceed to ERR2.
- ERR2:
  - HREADYOUT=1, HRESP=1.
  - Any address phase presented in ERR2 is decoded normally.
- Simultaneous events:
  - Write data phase plus a new write address phase: no stall. The new write is latched.
  - Read data phase plus a new write address phase: no conflict.
- HRDATA holds its last value outside RD / RD_STALL completion.
- Address wrap: addresses at or beyond BASE_ADDR+MEM_BYTES never alias to low memory; they take the ERROR path.

Decomposition:
- Package ahb3lite_pkg:
  - HTRANS codes, HSIZE codes, HRESP codes.
  - FSM state enum.
  - Function lane_mask(size, addr[1:0]) returning 4 bits.
- One sub-module: ahb3lite_addr_decode.
  - Combinational legality check and lane mask, producing {legal, word_addr, lanes}.
  - Reusable by the future data-side slave.

Test Plan:
- Single read: preload word 5 = 32'hDEADBEEF; NONSEQ read HADDR=0x14 -> next cycle HREADYOUT=1, HRESP=0, HRDATA=32'hDEADBEEF.
- Burst: INCR4 reads at 0x0..0xC, words = 1,2,3,4 -> four consecutive data phases 1,2,3,4, no wait states.
- Byte write then read: write byte 8'hA5 at 0x21 (HSIZE=0) onto word 32'h0 -> bram_we=4'b0010; immediately following read 0x20 -> one wait cycle (HREADYOUT=0), then HRDATA=32'h0000A500.
- Halfword write 16'h1234 at 0x32 -> bram_we=4'b1100, word 12 = 32'h1234xxxx with low half unchanged.
- Error: read HADDR=MEM_BYTES (0x4000) -> cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1, bram_en=0 throughout; same for misaligned word read at 0x2.
- Reset mid-write: assert HRESET during the WR data phase -> bram_we=0 in that cycle, memory unchanged; outputs at reset values next cycle.
